// File: rtl/stream_pkg.sv
// Shared types and the round-robin search helper for the stream arbiter family.
package stream_pkg;

  localparam int MAXREQ = 16;
  localparam int MAXW   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic            found;
    logic [MAXW-1:0] idx;
  } rr_pick_t;

  // First set bit of req, searching from (last+1) mod n upward with wrap.
  function automatic rr_pick_t rr_pick(input logic [MAXREQ-1:0] req,
                                       input logic [MAXW-1:0]   last,
                                       input int                n);
    rr_pick_t r;
    int       cand;
    r = '0;
    for (int k = 1; k <= MAXREQ; k++) begin
      if (k <= n && !r.found) begin
        cand = (int'(last) + k) % n;
        if (req[cand]) begin
          r.found = 1'b1;
          r.idx   = MAXW'(cand);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_frame_arbiter_pick.sv
// Combinational round-robin pick: rotate past the last winner, find first, unrotate.
module rr_priority_pick
  import stream_pkg::*;
#(
  parameter  int NREQ  = 4,
  localparam int GSIZE = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [GSIZE-1:0] last,
  output logic [GSIZE-1:0] idx,
  output logic             found
);

  rr_pick_t pick;

  always_comb pick = rr_pick(MAXREQ'(req), MAXW'(last), NREQ);

  // The range guard also keeps a non-power-of-two NREQ from ever producing an out-of-range index.
  assign idx   = pick.idx[GSIZE-1:0];
  assign found = pick.found & ({1'b0, pick.idx} < (MAXW+1)'(NREQ));

endmodule

// File: rtl/stream_frame_arbiter.sv
// Frame-atomic round-robin merge of NREQ valid/ready byte streams into one registered output.
//   state | meaning
//   IDLE  | arbitrating among itvalid & en_mask, no requester connected
//   BUSY  | requester 'grant' owns the output until its itlast beat is accepted
module stream_frame_arbiter
  import stream_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int DSIZE = 8,
  localparam int GSIZE = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       en_mask,
  input  logic [NREQ-1:0]       itvalid,
  output logic [NREQ-1:0]       itready,
  input  logic [NREQ*DSIZE-1:0] itdata,
  input  logic [NREQ-1:0]       itlast,
  output logic                  otvalid,
  input  logic                  otready,
  output logic [DSIZE-1:0]      otdata,
  output logic                  otlast,
  output logic                  busy,
  output logic [GSIZE-1:0]      grant
);

  arb_state_t       state, state_nxt;
  logic [GSIZE-1:0] grant_nxt;
  logic [GSIZE-1:0] rr_last, rr_last_nxt;
  logic [GSIZE-1:0] pick_idx;
  logic [NREQ-1:0]  req;
  logic             pick_found;
  logic             slot_free;
  logic             accept;
  logic             sel_valid;
  logic             sel_last;
  logic [DSIZE-1:0] sel_data;

  assign req = itvalid & en_mask;

  rr_priority_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .last  (rr_last),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign busy      = (state == BUSY);
  assign slot_free = ~otvalid | otready;
  assign sel_valid = itvalid[grant];
  assign sel_last  = itlast[grant];
  assign sel_data  = itdata[int'(grant)*DSIZE +: DSIZE];
  assign accept    = busy & slot_free & sel_valid;

  always_comb begin
    itready = '0;
    for (int i = 0; i < NREQ; i++) begin
      itready[i] = busy & slot_free & (grant == GSIZE'(i));
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    rr_last_nxt = rr_last;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt   = BUSY;
          grant_nxt   = pick_idx;
          rr_last_nxt = pick_idx;
        end
      end
      BUSY: begin
        if (accept && sel_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rr_last starts at NREQ-1 so the first search after reset begins at requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      rr_last <= GSIZE'(NREQ - 1);
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      rr_last <= rr_last_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      otvalid <= 1'b0;
      otdata  <= '0;
      otlast  <= 1'b0;
    end else if (accept) begin
      otvalid <= 1'b1;
      otdata  <= sel_data;
      otlast  <= sel_last;
    end else if (otready) begin
      otvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_frame_arbiter.sv
// Scoreboard bench for stream_frame_arbiter: per-requester source queues, hand-ordered expected beats.
module tb_stream_frame_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int GSIZE = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       en_mask;
  logic [NREQ-1:0]       itvalid;
  logic [NREQ-1:0]       itready;
  logic [NREQ*DSIZE-1:0] itdata;
  logic [NREQ-1:0]       itlast;
  logic                  otvalid;
  logic                  otready;
  logic [DSIZE-1:0]      otdata;
  logic                  otlast;
  logic                  busy;
  logic [GSIZE-1:0]      grant;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] src_q [NREQ][$];
  logic [8:0] exp_q [$];
  int         cyc = 0;
  bit         toggle_rdy = 1'b0;
  bit         gap_chk = 1'b0;
  bit         prev_last = 1'b0;
  int         last_cyc = -1;
  bit         hold_pend = 1'b0;
  logic [8:0] hold_val = '0;

  always #5 clk = ~clk;

  stream_frame_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE)) dut (
    .clk     (clk),
    .rst     (rst),
    .en_mask (en_mask),
    .itvalid (itvalid),
    .itready (itready),
    .itdata  (itdata),
    .itlast  (itlast),
    .otvalid (otvalid),
    .otready (otready),
    .otdata  (otdata),
    .otlast  (otlast),
    .busy    (busy),
    .grant   (grant)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_beat(input int r, input logic [7:0] d, input logic l);
    src_q[r].push_back({l, d});
  endtask

  task automatic exp_beat(input logic [7:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || otvalid) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) chk("drain_timeout", {31'd0, otvalid} | 32'(exp_q.size()), 32'd0);
  endtask

  // Source driver and output monitor: inputs change on the falling edge, handshakes sampled just after.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      otready = toggle_rdy ? cyc[0] : 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (src_q[i].size() > 0) begin
          itvalid[i]                  = 1'b1;
          itdata[i*DSIZE +: DSIZE]    = src_q[i][0][7:0];
          itlast[i]                   = src_q[i][0][8];
        end else begin
          itvalid[i]                  = 1'b0;
          itdata[i*DSIZE +: DSIZE]    = '0;
          itlast[i]                   = 1'b0;
        end
      end
      #1;
      if (rst) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          chk("hold_valid", 32'(otvalid), 32'd1);
          chk("hold_data", 32'({otlast, otdata}), 32'(hold_val));
        end
        if (otvalid && otready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 32'({otlast, otdata}), 32'h1ff);
          end else begin
            e = exp_q.pop_front();
            chk("beat", 32'({otlast, otdata}), 32'(e));
            if (gap_chk && last_cyc >= 0) begin
              if (prev_last) chk("frame_gap", 32'(cyc - last_cyc), 32'd2);
              else           chk("beat_rate", 32'(cyc - last_cyc), 32'd1);
            end
            prev_last = otlast;
            last_cyc  = cyc;
          end
        end
        hold_pend = otvalid && !otready;
        hold_val  = {otlast, otdata};
        for (int i = 0; i < NREQ; i++) begin
          if (itvalid[i] && itready[i]) void'(src_q[i].pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst     = 1'b1;
    en_mask = '1;
    otready = 1'b1;
    itvalid = '0;
    itdata  = '0;
    itlast  = '0;

    // Reset with all sources valid, then round-robin over 2-beat frames.
    for (int r = 0; r < NREQ; r++) begin
      load_beat(r, 8'(8'hA0 + r), 1'b0);
      load_beat(r, 8'(8'hB0 + r), 1'b1);
      exp_beat(8'(8'hA0 + r), 1'b0);
      exp_beat(8'(8'hB0 + r), 1'b1);
    end
    load_beat(0, 8'hA0, 1'b0);
    load_beat(0, 8'hB0, 1'b1);
    exp_beat(8'hA0, 1'b0);
    exp_beat(8'hB0, 1'b1);
    gap_chk  = 1'b1;
    last_cyc = -1;
    repeat (3) begin
      @(negedge clk);
      #2;
      chk("rst_otvalid", 32'(otvalid), 32'd0);
      chk("rst_itready", 32'(itready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
    end
    @(negedge clk);
    #3;
    rst = 1'b0;
    tick();
    chk("first_busy", 32'(busy), 32'd1);
    chk("first_grant", 32'(grant), 32'd0);
    wait_drain(300);
    gap_chk = 1'b0;

    // Backpressure: requester 1's frame must stay contiguous ahead of requester 2.
    toggle_rdy = 1'b1;
    for (int b = 0; b < 5; b++) begin
      load_beat(1, 8'(8'h10 + b), b == 4);
      exp_beat(8'(8'h10 + b), b == 4);
    end
    for (int b = 0; b < 3; b++) begin
      load_beat(2, 8'(8'h20 + b), b == 2);
      exp_beat(8'(8'h20 + b), b == 2);
    end
    wait_drain(300);
    toggle_rdy = 1'b0;

    // Mask: requester 2 blocked; requester 1 masked mid-frame still finishes, then is skipped.
    en_mask = 4'b1011;
    load_beat(0, 8'h30, 1'b0);
    load_beat(0, 8'h31, 1'b1);
    for (int b = 0; b < 6; b++) load_beat(1, 8'(8'h40 + b), b == 5);
    load_beat(1, 8'h48, 1'b1);
    load_beat(2, 8'h50, 1'b1);
    load_beat(3, 8'h60, 1'b1);
    exp_beat(8'h60, 1'b1);
    exp_beat(8'h30, 1'b0);
    exp_beat(8'h31, 1'b1);
    for (int b = 0; b < 6; b++) exp_beat(8'(8'h40 + b), b == 5);
    k = 0;
    while (!(busy && grant == 2'd1) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) chk("mask_wait", 32'(busy && grant == 2'd1), 32'd1);
    repeat (2) tick();
    en_mask = 4'b1001;
    wait_drain(200);
    repeat (5) tick();
    chk("mask_idle_busy", 32'(busy), 32'd0);
    chk("mask_last_grant", 32'(grant), 32'd1);
    chk("mask_idle_otvalid", 32'(otvalid), 32'd0);
    en_mask = 4'hF;
    exp_beat(8'h50, 1'b1);
    exp_beat(8'h48, 1'b1);
    wait_drain(200);

    // Wrap: requester 3 ends a frame while 0 and 3 are both valid; 0 must win next.
    load_beat(3, 8'h70, 1'b0);
    load_beat(3, 8'h71, 1'b1);
    load_beat(3, 8'h78, 1'b1);
    load_beat(0, 8'h80, 1'b1);
    exp_beat(8'h70, 1'b0);
    exp_beat(8'h71, 1'b1);
    exp_beat(8'h80, 1'b1);
    exp_beat(8'h78, 1'b1);
    wait_drain(200);
    chk("wrap_last_grant", 32'(grant), 32'd3);

    // Async reset between edges during beat 2 of 4, then arbitration restarts at requester 0.
    for (int b = 0; b < 4; b++) begin
      load_beat(2, 8'(8'h90 + b), b == 3);
      exp_beat(8'(8'h90 + b), b == 3);
    end
    k = 0;
    while (!(otvalid && otdata == 8'h91) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) chk("arst_wait", 32'(otdata), 32'h91);
    rst = 1'b1;
    #1;
    chk("arst_otvalid", 32'(otvalid), 32'd0);
    chk("arst_otdata", 32'(otdata), 32'd0);
    chk("arst_otlast", 32'(otlast), 32'd0);
    chk("arst_itready", 32'(itready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_grant", 32'(grant), 32'd0);
    exp_q.delete();
    src_q[2].delete();
    @(negedge clk);
    #3;
    rst = 1'b0;
    load_beat(1, 8'hC1, 1'b1);
    load_beat(3, 8'hC3, 1'b1);
    exp_beat(8'hC1, 1'b1);
    exp_beat(8'hC3, 1'b1);
    wait_drain(200);
    chk("arst_last_grant", 32'(grant), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
